// File: rtl/ppu_oam_scan_if.sv
// OAM read bus between the mode-2 scanner and the memory map's PPU port.
// The scanner presents an address; the memory returns that byte one cycle later.
interface ppu_oam_scan_if;
  logic [7:0] oam_addr;
  logic       oam_read_en;
  logic [7:0] oam_data;

  modport master (
    output oam_addr,
    output oam_read_en,
    input  oam_data
  );

  modport slave (
    input  oam_addr,
    input  oam_read_en,
    output oam_data
  );
endinterface

// File: rtl/ppu_oam_scan.sv
// PPU mode-2 OAM search: scans 40 OAM entries and buffers up to 10 sprites hitting line ly.
// Define OAM_SCAN_SORT_X_EN to keep the buffer sorted by ascending X (ties by OAM index).
module ppu_oam_scan #(
  parameter int unsigned NUM_ENTRIES = 40,
  parameter int unsigned MAX_SPRITES = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            ly,
  input  logic                  tall_sprites,
  ppu_oam_scan_if.master        oam,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            sprite_count,
  input  logic [3:0]            rd_index,
  output logic                  rd_valid,
  output logic [5:0]            rd_oam_index,
  output logic [7:0]            rd_y,
  output logic [7:0]            rd_x
);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

  localparam logic [6:0] LAST_K     = 7'(2 * NUM_ENTRIES - 1);
  localparam logic [5:0] LAST_ENTRY = 6'(NUM_ENTRIES - 1);
  localparam logic [3:0] MAX_COUNT  = 4'(MAX_SPRITES);

  state_t      state;
  state_t      state_next;
  logic [6:0]  k;
  logic [7:0]  ly_q;
  logic        tall_q;
  logic [7:0]  y_q;

  logic [5:0]  slot_idx [MAX_SPRITES];
  logic [7:0]  slot_y   [MAX_SPRITES];
  logic [7:0]  slot_x   [MAX_SPRITES];

  logic        eval_en;
  logic [5:0]  eval_entry;
  logic [8:0]  line_pos;
  logic [8:0]  height;
  logic [8:0]  y_ext;
  logic        hit;
  logic        accept;

  always_comb begin
    state_next      = state;
    oam.oam_addr    = '0;
    oam.oam_read_en = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = SCAN;
      end
      SCAN: begin
        // Even k reads the Y byte, odd k the X byte of entry k>>1.
        oam.oam_addr    = {k[6:1], 1'b0, k[0]};
        oam.oam_read_en = 1'b1;
        busy            = 1'b1;
        if (k == LAST_K) state_next = FLUSH;
      end
      FLUSH: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Data arrives one cycle after its address, so an entry is judged on the
  // cycle after its X address went out (the last one during FLUSH).
  always_comb begin
    eval_en    = ((state == SCAN) && (k != '0) && !k[0]) || (state == FLUSH);
    eval_entry = (state == FLUSH) ? LAST_ENTRY : (k[6:1] - 6'd1);
    line_pos   = {1'b0, ly_q} + 9'd16;
    height     = tall_q ? 9'd16 : 9'd8;
    y_ext      = {1'b0, y_q};
    hit        = (line_pos >= y_ext) && (line_pos < (y_ext + height));
    accept     = eval_en && hit && (sprite_count < MAX_COUNT);
  end

`ifdef OAM_SCAN_SORT_X_EN
  logic [3:0] ins_pos;

  // Slots are already sorted, so the insert point is the number of valid
  // slots whose X does not exceed the new X (ties keep earlier OAM entries first).
  always_comb begin
    ins_pos = '0;
    for (int unsigned i = 0; i < MAX_SPRITES; i++) begin
      if ((4'(i) < sprite_count) && (slot_x[i] <= oam.oam_data)) ins_pos = ins_pos + 4'd1;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      k            <= '0;
      ly_q         <= '0;
      tall_q       <= 1'b0;
      y_q          <= '0;
      sprite_count <= '0;
      for (int unsigned i = 0; i < MAX_SPRITES; i++) begin
        slot_idx[i] <= '0;
        slot_y[i]   <= '0;
        slot_x[i]   <= '0;
      end
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            ly_q         <= ly;
            tall_q       <= tall_sprites;
            k            <= '0;
            sprite_count <= '0;
            for (int unsigned i = 0; i < MAX_SPRITES; i++) begin
              slot_idx[i] <= '0;
              slot_y[i]   <= '0;
              slot_x[i]   <= '0;
            end
          end
        end
        SCAN: begin
          k <= k + 7'd1;
          if (k[0]) y_q <= oam.oam_data;
        end
        default: ;
      endcase

      if (accept) begin
        sprite_count <= sprite_count + 4'd1;
`ifdef OAM_SCAN_SORT_X_EN
        for (int unsigned i = 1; i < MAX_SPRITES; i++) begin
          if ((4'(i) > ins_pos) && (4'(i) <= sprite_count)) begin
            slot_idx[i] <= slot_idx[i-1];
            slot_y[i]   <= slot_y[i-1];
            slot_x[i]   <= slot_x[i-1];
          end
        end
        for (int unsigned i = 0; i < MAX_SPRITES; i++) begin
          if (4'(i) == ins_pos) begin
            slot_idx[i] <= eval_entry;
            slot_y[i]   <= y_q;
            slot_x[i]   <= oam.oam_data;
          end
        end
`else
        for (int unsigned i = 0; i < MAX_SPRITES; i++) begin
          if (4'(i) == sprite_count) begin
            slot_idx[i] <= eval_entry;
            slot_y[i]   <= y_q;
            slot_x[i]   <= oam.oam_data;
          end
        end
`endif
      end
    end
  end

  always_comb begin
    rd_valid     = 1'b0;
    rd_oam_index = '0;
    rd_y         = '0;
    rd_x         = '0;
    for (int unsigned i = 0; i < MAX_SPRITES; i++) begin
      if ((rd_index == 4'(i)) && (4'(i) < sprite_count)) begin
        rd_valid     = 1'b1;
        rd_oam_index = slot_idx[i];
        rd_y         = slot_y[i];
        rd_x         = slot_x[i];
      end
    end
  end

endmodule

// File: tb/tb_ppu_oam_scan.sv
// Scoreboard bench for ppu_oam_scan: directed OAM images with hand-computed sprite lists,
// checked by a monitor that pops the expected result on every done pulse.
module tb_ppu_oam_scan;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] ly;
  logic       tall_sprites;
  logic       busy;
  logic       done;
  logic [3:0] sprite_count;
  logic [3:0] rd_index;
  logic       rd_valid;
  logic [5:0] rd_oam_index;
  logic [7:0] rd_y;
  logic [7:0] rd_x;

  ppu_oam_scan_if oam ();

  ppu_oam_scan #(.NUM_ENTRIES(40), .MAX_SPRITES(10)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .ly           (ly),
    .tall_sprites (tall_sprites),
    .oam          (oam),
    .busy         (busy),
    .done         (done),
    .sprite_count (sprite_count),
    .rd_index     (rd_index),
    .rd_valid     (rd_valid),
    .rd_oam_index (rd_oam_index),
    .rd_y         (rd_y),
    .rd_x         (rd_x)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [256];
  always @(posedge clock) begin
    if (oam.oam_read_en) oam.oam_data <= mem[oam.oam_addr];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic       log_en = 1'b0;
  logic [7:0] addr_q[$];
  always @(negedge clock) begin
    if (log_en && oam.oam_read_en) addr_q.push_back(oam.oam_addr);
  end

  typedef struct packed {
    logic [31:0]      done_cyc;
    logic [3:0]       count;
    logic [9:0][5:0]  idx;
    logic [9:0][7:0]  y;
    logic [9:0][7:0]  x;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int mon_seen = 0;

  logic       mon_active = 1'b0;
  logic [3:0] mon_idx    = '0;
  logic [3:0] main_idx   = '0;
  assign rd_index = mon_active ? mon_idx : main_idx;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, act, expv);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", int'(done), 0);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", cyc, int'(e.done_cyc));
          check("busy_at_done", int'(busy), 0);
          check("sprite_count", int'(sprite_count), int'(e.count));
          mon_active = 1'b1;
          for (int j = 0; j < 16; j++) begin
            mon_idx = 4'(j);
            #1;
            if (j < int'(e.count)) begin
              check($sformatf("slot%0d_valid", j), int'(rd_valid), 1);
              check($sformatf("slot%0d_index", j), int'(rd_oam_index), int'(e.idx[j]));
              check($sformatf("slot%0d_y", j), int'(rd_y), int'(e.y[j]));
              check($sformatf("slot%0d_x", j), int'(rd_x), int'(e.x[j]));
            end else begin
              check($sformatf("slot%0d_valid", j), int'(rd_valid), 0);
              check($sformatf("slot%0d_fields", j), int'({rd_oam_index, rd_y, rd_x}), 0);
            end
          end
          mon_active = 1'b0;
          mon_seen++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got cycle %0d, want completion", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic set_entry(input int ent, input int yv, input int xv);
    mem[4*ent]   = 8'(yv);
    mem[4*ent+1] = 8'(xv);
  endtask

  task automatic issue_start(input logic [7:0] l, input logic t, output int n);
    @(negedge clock);
    ly           = l;
    tall_sprites = t;
    start        = 1'b1;
    n            = cyc;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_mon(input int target);
    for (int c = 0; c < 200 && mon_seen < target; c++) @(negedge clock);
    check("scan_finished", mon_seen, target);
  endtask

  task automatic push_exp(input exp_t e, input int n);
    e.done_cyc = 32'(n + 82);
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    int   n;
    reset        = 1'b1;
    start        = 1'b0;
    ly           = '0;
    tall_sprites = 1'b0;
    clear_mem();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    check("idle_read_en", int'(oam.oam_read_en), 0);
    check("idle_addr", int'(oam.oam_addr), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_done", int'(done), 0);
    check("idle_count", int'(sprite_count), 0);
    for (int i = 0; i < 16; i++) begin
      main_idx = 4'(i);
      #1;
      check($sformatf("idle_rd_valid%0d", i), int'(rd_valid), 0);
    end
    main_idx = '0;

    // Four sprites on line 0, all X=0
    for (int i = 0; i < 4; i++) set_entry(i, 16, 0);
    e = '0;
    e.count = 4'd4;
    for (int i = 0; i < 4; i++) begin e.idx[i] = 6'(i); e.y[i] = 8'd16; end
    addr_q.delete();
    log_en = 1'b1;
    issue_start(8'd0, 1'b0, n);
    push_exp(e, n);
    wait_mon(1);
    log_en = 1'b0;
    check("addr_count", addr_q.size(), 80);
    for (int k = 0; k < 80 && k < addr_q.size(); k++)
      check($sformatf("addr%0d", k), int'(addr_q[k]), 4*(k/2) + (k%2));

    // Fifteen hits: only the first ten in OAM order kept
    clear_mem();
    for (int i = 0; i < 15; i++) set_entry(i, 20, i);
    e = '0;
    e.count = 4'd10;
    for (int i = 0; i < 10; i++) begin e.idx[i] = 6'(i); e.y[i] = 8'd20; e.x[i] = 8'(i); end
    issue_start(8'd5, 1'b0, n);
    push_exp(e, n);
    wait_mon(2);

    // Y=10, ly=9 -> L=25: outside 8x8, inside 8x16
    clear_mem();
    set_entry(0, 10, 0);
    e = '0;
    issue_start(8'd9, 1'b0, n);
    push_exp(e, n);
    wait_mon(3);
    e = '0;
    e.count = 4'd1;
    e.y[0]  = 8'd10;
    issue_start(8'd9, 1'b1, n);
    push_exp(e, n);
    wait_mon(4);

    // ly=143 -> L=159: Y=160 misses, Y=152 hits
    clear_mem();
    set_entry(0, 160, 3);
    set_entry(1, 152, 7);
    e = '0;
    e.count  = 4'd1;
    e.idx[0] = 6'd1;
    e.y[0]   = 8'd152;
    e.x[0]   = 8'd7;
    issue_start(8'd143, 1'b0, n);
    push_exp(e, n);
    wait_mon(5);

    // Extra start pulses at cycle 40 (scan) and 82 (done) are ignored
    clear_mem();
    for (int i = 0; i < 4; i++) set_entry(i, 16, 0);
    e = '0;
    e.count = 4'd4;
    for (int i = 0; i < 4; i++) begin e.idx[i] = 6'(i); e.y[i] = 8'd16; end
    @(negedge clock);
    ly           = 8'd0;
    tall_sprites = 1'b0;
    start        = 1'b1;
    n            = cyc;
    push_exp(e, n);
    for (int c = 1; c <= 84; c++) begin
      @(negedge clock);
      start = (c == 40) || (c == 82);
      if (c == 83) check("busy_after_done_start", int'(busy), 0);
      if (c == 84) check("read_en_after_done_start", int'(oam.oam_read_en), 0);
    end
    start = 1'b0;
    wait_mon(6);

    // Reset at cycle 40 aborts the scan
    @(negedge clock);
    start = 1'b1;
    for (int c = 1; c <= 41; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (c == 39) check("count_before_reset", int'(sprite_count), 4);
      reset = (c == 40);
    end
    check("reset_busy", int'(busy), 0);
    check("reset_read_en", int'(oam.oam_read_en), 0);
    check("reset_count", int'(sprite_count), 0);
    main_idx = '0;
    #1;
    check("reset_rd_valid", int'(rd_valid), 0);
    reset = 1'b0;
    repeat (100) @(negedge clock);
    check("reset_no_done_count", int'(sprite_count), 0);

    // X ordering: X=50,20,20,80
    clear_mem();
    set_entry(0, 16, 50);
    set_entry(1, 16, 20);
    set_entry(2, 16, 20);
    set_entry(3, 16, 80);
    e = '0;
    e.count = 4'd4;
    for (int i = 0; i < 4; i++) e.y[i] = 8'd16;
`ifdef OAM_SCAN_SORT_X_EN
    e.idx[0] = 6'd1; e.x[0] = 8'd20;
    e.idx[1] = 6'd2; e.x[1] = 8'd20;
    e.idx[2] = 6'd0; e.x[2] = 8'd50;
    e.idx[3] = 6'd3; e.x[3] = 8'd80;
`else
    e.idx[0] = 6'd0; e.x[0] = 8'd50;
    e.idx[1] = 6'd1; e.x[1] = 8'd20;
    e.idx[2] = 6'd2; e.x[2] = 8'd20;
    e.idx[3] = 6'd3; e.x[3] = 8'd80;
`endif
    issue_start(8'd0, 1'b0, n);
    push_exp(e, n);
    wait_mon(7);

    repeat (5) @(negedge clock);
    check("leftover_expectations", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ppu_oam_scan.md
# ppu_oam_scan

PPU mode-2 (OAM search) stage for one scanline. It reads Y/X bytes of all 40 OAM entries through the PPU read port of the memory map and selects up to 10 sprites whose rows intersect the current line. It stores their index/X/Y in a small buffer for the downstream sprite fetcher. It drives the memory map's PPU OAM address/read-enable and consumes its PPU data output.

## Interface
Parameters:
- NUM_ENTRIES, 40, OAM entries scanned per line (4 bytes each)
- MAX_SPRITES, 10, buffer depth / per-line sprite limit

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  system clock (one PPU dot per cycle)
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse: begin scan of line `ly`
- ly  in  8  current line, sampled on accepted `start`
- tall_sprites  in  1  LCDC.2, 1 = 8x16; sampled on accepted `start`
- oam_addr  out  8  to memory `ppu_addr[7:0]`
- oam_read_en  out  1  to memory `ppu_oam_read_en` (PPU owns OAM, CPU blocked)
- oam_data  in  8  from memory `ppu_data_out` (memory `ppu_read_mode`=0); byte for address presented one cycle earlier
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse, results valid
- sprite_count  out  4  accepted sprites, 0..MAX_SPRITES
- rd_index  in  4  buffer slot to read (combinational)
- rd_valid  out  1  rd_index < sprite_count
- rd_oam_index  out  6  OAM entry number of slot
- rd_y, rd_x  out  8 each  raw OAM Y/X bytes of slot

## Operation
- States: IDLE -> SCAN -> FLUSH -> DONE -> IDLE.
- IDLE: `start`=1 latches ly/tall_sprites, clears sprite_count and buffer, goes to SCAN with k=0.
- SCAN (k=0..79): oam_addr = 4*(k>>1) + k[0]; oam_read_en=1. From k=1, oam_data is byte for address of k-1. If that address is even, latch it as Y. If it is odd, it is X: evaluate entry (k-1)>>1. After k=79 -> FLUSH.
- FLUSH: oam_read_en=0, oam_addr=0; evaluate entry 39 with oam_data as X; -> DONE.
- DONE: done=1 for one cycle; -> IDLE.
- Match rule, 9-bit unsigned math: L = ly+16, H = tall_sprites?16:8; hit iff L >= Y and L < Y+H. X is ignored (X=0 still counts).
- On hit with sprite_count < MAX_SPRITES: write {entry, Y, X} into slot sprite_count, increment. Hits once full are dropped.
- `start` while not IDLE: ignored.
- Buffer and sprite_count held from DONE until next accepted `start`.
- rd_*: rd_valid=0 and fields 0 when rd_index >= sprite_count.
- Reset values: state IDLE, oam_addr 0, oam_read_en 0, busy 0, done 0, sprite_count 0, buffer all 0.
- Reset mid-scan: IDLE next cycle, all outputs at reset values; partial results discarded.

## Timing
- Cycle 0: `start` sampled in IDLE.
- Cycles 1..80: SCAN, oam_read_en=1.
- Cycle 81: FLUSH.
- Cycle 82: done=1.
- busy=1 cycles 1..81. Total latency start -> done: 82 cycles.
- Memory OAM read latency assumed exactly 1 cycle. Addresses must be issued back to back, with no bubbles.
- sprite_count updates the cycle after the X byte is seen. The final value is stable when done=1.
- `start` at cycle 82 (during DONE) is ignored. Earliest next accepted start is cycle 83.

## Configuration
- OAM_SCAN_SORT_X_EN defined: accepted sprites are insertion-sorted into the buffer by ascending X, ties by ascending OAM index. The insertion is a one-cycle parallel shift of slots whose X > new X. Slot 0 is the highest-priority sprite. The 10-sprite limit is still applied in OAM order: later entries never displace earlier ones.
- Not defined: buffer is in OAM-index order; no sort logic is built.

## Test plan
- Reset, then idle 5 cycles -> oam_read_en=0, busy=0, done=0, sprite_count=0, rd_valid=0 for all rd_index.
- OAM entries 0..3 Y=16, others Y=0, ly=0, 8x8, start -> done exactly at cycle 82. Also check sprite_count=4, rd_oam_index 0,1,2,3, and oam_addr sequence 0,1,4,5,...,156,157.
- Entries 0..14 Y=20 X=i, ly=5 -> sprite_count=10, slots hold entries 0..9; entries 10..14 dropped.
- Entry 0 Y=10, ly=9 (L=25): with tall_sprites=0, count 0; with tall_sprites=1, count 1. Entry Y=160 with ly=143 -> no hit. Entry Y=152 -> hit.
- Second start pulse at cycle 40 -> ignored, done still at 82. Reset at cycle 40 -> busy=0 and oam_read_en=0 at cycle 41, sprite_count=0.
- With OAM_SCAN_SORT_X_EN, entries 0..3 hit with X=50,20,20,80 -> slots hold rd_oam_index 1,2,0,3. Without the macro, slots hold 0,1,2,3.
